// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences the program ROM over the control bus,
// captures each instruction word and hands it to execute over valid/ready.
module fetch_sequencer #(
  parameter int         PC_W     = 4,
  parameter int         INSTR_W  = 14,
  parameter logic [1:0] ROM_DEV  = 2'b11,
  parameter logic [1:0] IDLE_DEV = 2'b00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  output logic [1:0]         dev_sel,
  output logic [PC_W-1:0]    opaddr,
  input  logic [INSTR_W-1:0] bus_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jmp_valid,
  input  logic [PC_W-1:0]    jmp_target,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_CAPTURE = 3'd2,
    S_ISSUE   = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [PC_W-1:0]      pc_r, pc_s;
  logic [INSTR_W-1:0]   instr_r, instr_s;
  logic [1:0]           dev_sel_r, dev_sel_s;
  logic                 instr_valid_r, instr_valid_s;
  logic                 halted_r, halted_s;

  // Next-state, PC and capture logic; the flag outputs are decoded from the
  // next state so they can be registered alongside it.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    case (state_r)
      S_IDLE: begin
        if (run) state_s = S_ADDR;
        else     state_s = S_IDLE;
      end
      S_ADDR: begin
        state_s = S_CAPTURE;
      end
      S_CAPTURE: begin
        instr_s = bus_data;
        state_s = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) begin
          if (jmp_valid) pc_s = jmp_target;
          else           pc_s = pc_r + PC_W'(1);
          if (halt_req)  state_s = S_HALT;
          else           state_s = S_ADDR;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_HALT: begin
        if (run && !halt_req) state_s = S_ADDR;
        else                  state_s = S_HALT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if ((state_s == S_ADDR) || (state_s == S_CAPTURE)) dev_sel_s = ROM_DEV;
    else                                                dev_sel_s = IDLE_DEV;
    instr_valid_s = (state_s == S_ISSUE);
    halted_s      = (state_s == S_HALT);
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      pc_r          <= '0;
      instr_r       <= '0;
      dev_sel_r     <= IDLE_DEV;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= instr_s;
      dev_sel_r     <= dev_sel_s;
      instr_valid_r <= instr_valid_s;
      halted_r      <= halted_s;
    end
  end

  assign dev_sel     = dev_sel_r;
  assign opaddr      = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 16-word ROM model
// that drives the data bus only while the ROM is selected.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic [1:0]  dev_sel;
  logic [3:0]  opaddr;
  logic [13:0] bus_data;
  logic [13:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jmp_valid = 1'b0;
  logic [3:0]  jmp_target = 4'h0;
  logic [3:0]  pc;
  logic        halted;

  logic [13:0] rom [16];
  logic [13:0] bus_garbage = 14'h2AAA;
  int checks = 0;
  int errors = 0;

  assign bus_data = (dev_sel == 2'b11) ? rom[opaddr] : bus_garbage;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .dev_sel(dev_sel), .opaddr(opaddr), .bus_data(bus_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task tick;
    @(negedge clk);
  endtask

  task test_reset;
    #1 rst = 1'b1;
    #1;
    checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL rst_dev_sel got %h exp 0", dev_sel); end
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL rst_opaddr got %h exp 0", opaddr); end
    checks++; if (pc !== 4'h0)          begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
    checks++; if (instr !== 14'h0)      begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
    tick; tick;
    rst = 1'b0;
    tick; tick;
    checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL idle_dev_sel got %h exp 0", dev_sel); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", instr_valid); end
  endtask

  task test_first_fetch;
    run = 1'b1; instr_ready = 1'b1;
    tick;
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL ff_addr_dev_sel got %h exp 3", dev_sel); end
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL ff_addr_opaddr got %h exp 0", opaddr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_addr_valid got %b exp 0", instr_valid); end
    tick;
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL ff_cap_dev_sel got %h exp 3", dev_sel); end
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL ff_cap_opaddr got %h exp 0", opaddr); end
    tick;
    checks++; if (instr !== 14'h0C0A)   begin errors++; $display("FAIL ff_instr got %h exp 0c0a", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got %b exp 1", instr_valid); end
    checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL ff_issue_dev_sel got %h exp 0", dev_sel); end
    tick;
    checks++; if (pc !== 4'h1)          begin errors++; $display("FAIL ff_pc_after got %h exp 1", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_valid_fall got %b exp 0", instr_valid); end
    instr_ready = 1'b0;
  endtask

  task test_backpressure;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      bus_garbage = 14'(i * 777);
      checks++; if (instr !== 14'h0D1B)   begin errors++; $display("FAIL bp_instr[%0d] got %h exp 0d1b", i, instr); end
      checks++; if (pc !== 4'h1)          begin errors++; $display("FAIL bp_pc[%0d] got %h exp 1", i, pc); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL bp_dev_sel[%0d] got %h exp 0", i, dev_sel); end
      tick;
    end
    instr_ready = 1'b1;
    tick;
    checks++; if (pc !== 4'h2)          begin errors++; $display("FAIL bp_pc_after got %h exp 2", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", instr_valid); end
  endtask

  task test_back_to_back;
    logic [3:0]  exp_pc;
    logic [3:0]  prev_pc;
    logic [1:0]  exp_dev;
    logic [13:0] exp_instr;
    int          phase;
    for (int k = 0; k < 9; k++) begin
      phase     = k % 3;
      exp_pc    = 4'(2 + k / 3);
      prev_pc   = exp_pc - 4'h1;
      exp_dev   = (phase < 2) ? 2'b11 : 2'b00;
      exp_instr = (phase == 2) ? rom[exp_pc] : rom[prev_pc];
      checks++; if (dev_sel !== exp_dev)              begin errors++; $display("FAIL b2b_dev_sel[%0d] got %h exp %h", k, dev_sel, exp_dev); end
      checks++; if (instr_valid !== (phase == 2))     begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", k, instr_valid, (phase == 2)); end
      checks++; if (opaddr !== exp_pc)                begin errors++; $display("FAIL b2b_opaddr[%0d] got %h exp %h", k, opaddr, exp_pc); end
      checks++; if (instr !== exp_instr)              begin errors++; $display("FAIL b2b_instr[%0d] got %h exp %h", k, instr, exp_instr); end
      if (k == 8) begin
        jmp_valid = 1'b1; jmp_target = 4'hF;
      end else begin
        bus_garbage = 14'($urandom);
      end
      tick;
    end
  endtask

  task test_wrap;
    jmp_valid = 1'b0;
    checks++; if (opaddr !== 4'hF)      begin errors++; $display("FAIL wrap_jump_opaddr got %h exp f", opaddr); end
    tick; tick;
    checks++; if (instr !== rom[15])    begin errors++; $display("FAIL wrap_instr got %h exp %h", instr, rom[15]); end
    checks++; if (pc !== 4'hF)          begin errors++; $display("FAIL wrap_pc15 got %h exp f", pc); end
    tick;
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL wrap_opaddr got %h exp 0", opaddr); end
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL wrap_dev_sel got %h exp 3", dev_sel); end
  endtask

  task test_jump_halt;
    halt_req = 1'b1; instr_ready = 1'b0;
    tick;
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL jh_cap_dev_sel got %h exp 3", dev_sel); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL jh_cap_halted got %b exp 0", halted); end
    tick;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL jh_issue_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== 14'h0C0A)   begin errors++; $display("FAIL jh_issue_instr got %h exp 0c0a", instr); end
    jmp_valid = 1'b1; jmp_target = 4'h7; instr_ready = 1'b1;
    tick;
    jmp_valid = 1'b0; jmp_target = 4'h3; bus_garbage = 'z;
    checks++; if (halted !== 1'b1)      begin errors++; $display("FAIL jh_halted got %b exp 1", halted); end
    checks++; if (pc !== 4'h7)          begin errors++; $display("FAIL jh_pc got %h exp 7", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jh_valid got %b exp 0", instr_valid); end
    checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL jh_dev_sel got %h exp 0", dev_sel); end
    tick;
    checks++; if (halted !== 1'b1)      begin errors++; $display("FAIL jh_hold_halt_req got %b exp 1", halted); end
    halt_req = 1'b0; run = 1'b0;
    tick;
    checks++; if (halted !== 1'b1)      begin errors++; $display("FAIL jh_hold_no_run got %b exp 1", halted); end
    checks++; if (instr !== 14'h0C0A)   begin errors++; $display("FAIL jh_instr_kept got %h exp 0c0a", instr); end
    run = 1'b1;
    tick;
    checks++; if (opaddr !== 4'h7)      begin errors++; $display("FAIL jh_resume_opaddr got %h exp 7", opaddr); end
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL jh_resume_dev_sel got %h exp 3", dev_sel); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL jh_resume_halted got %b exp 0", halted); end
  endtask

  task test_async_reset;
    tick;
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL ar_cap_dev_sel got %h exp 3", dev_sel); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dev_sel !== 2'b00)    begin errors++; $display("FAIL ar_dev_sel got %h exp 0", dev_sel); end
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL ar_opaddr got %h exp 0", opaddr); end
    checks++; if (pc !== 4'h0)          begin errors++; $display("FAIL ar_pc got %h exp 0", pc); end
    checks++; if (instr !== 14'h0)      begin errors++; $display("FAIL ar_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", instr_valid); end
    checks++; if (halted !== 1'b0)      begin errors++; $display("FAIL ar_halted got %b exp 0", halted); end
    tick; tick;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_held_valid got %b exp 0", instr_valid); end
    rst = 1'b0;
    tick;
    checks++; if (opaddr !== 4'h0)      begin errors++; $display("FAIL ar_restart_opaddr got %h exp 0", opaddr); end
    checks++; if (dev_sel !== 2'b11)    begin errors++; $display("FAIL ar_restart_dev_sel got %h exp 3", dev_sel); end
    tick; tick;
    checks++; if (instr !== 14'h0C0A)   begin errors++; $display("FAIL ar_restart_instr got %h exp 0c0a", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ar_restart_valid got %b exp 1", instr_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 14'(14'h0C0A + i * 14'h0111);
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_back_to_back;
    test_wrap;
    test_jump_halt;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
